// File: rtl/fifo_wr_front.sv
// fifo_wr_front -- write-side front end of an asynchronous FIFO.
//   Puts a 2-entry in-order skid buffer between the upstream valid/ready
//   source and the write-pointer/memory stage. Brings the read-domain Gray
//   pointer across with a 2-flop synchronizer and computes the occupancy
//   level and the almost-full flag, both registered.
// Ports:
//   w_clk, w_rst        write clock, async active-low reset
//   s_valid/s_data      upstream word offer
//   s_ready             registered, buffer can take a word
//   w_en/w_data         write request and oldest buffered word
//   full                registered full flag from the write-pointer stage
//   w_ptr_bin           binary write pointer (includes wrap bit)
//   rd_ptr_gray         Gray read pointer, read-clock domain
//   rd_ptr_gray_sync    synchronized Gray read pointer
//   wr_level            registered occupancy seen from the write side
//   almost_full         registered, wr_level >= AF_THRESH
module fifo_wr_front #(
  parameter int NUM_BITS  = 4,
  parameter int DATA_W    = 8,
  parameter int AF_THRESH = 6
) (
  input  logic                w_clk,
  input  logic                w_rst,
  input  logic                s_valid,
  input  logic [DATA_W-1:0]   s_data,
  output logic                s_ready,
  output logic                w_en,
  output logic [DATA_W-1:0]   w_data,
  input  logic                full,
  input  logic [NUM_BITS-1:0] w_ptr_bin,
  input  logic [NUM_BITS-1:0] rd_ptr_gray,
  output logic [NUM_BITS-1:0] rd_ptr_gray_sync,
  output logic [NUM_BITS-1:0] wr_level,
  output logic                almost_full
);

  localparam logic [NUM_BITS-1:0] AF_LVL = NUM_BITS'(AF_THRESH);

  // ---------------- skid buffer ----------------
  // buf0 is always the head; buf1 holds the second word when count==2.
  logic [1:0]        count_q, count_d;
  logic [DATA_W-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic              s_ready_q, s_ready_d;
  logic              push, pop;

  assign push   = s_valid & s_ready_q;
  assign pop    = w_en & ~full;
  assign w_en   = (count_q != 2'd0);
  assign w_data = buf0_q;
  assign s_ready = s_ready_q;

  always_comb begin
    count_d = count_q;
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    unique case ({push, pop})
      2'b11: begin
        // Count unchanged; incoming word goes behind whatever remains.
        if (count_q == 2'd2) begin
          buf0_d = buf1_q;
          buf1_d = s_data;
        end else begin
          buf0_d = s_data;
        end
      end
      2'b01: begin
        buf0_d  = buf1_q;
        count_d = count_q - 2'd1;
      end
      2'b10: begin
        if (count_q == 2'd0) buf0_d = s_data;
        else                 buf1_d = s_data;
        count_d = count_q + 2'd1;
      end
      default: ;
    endcase
    s_ready_d = (count_d < 2'd2);
  end

  always_ff @(posedge w_clk or negedge w_rst) begin
    if (!w_rst) begin
      count_q   <= '0;
      buf0_q    <= '0;
      buf1_q    <= '0;
      s_ready_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      buf0_q    <= buf0_d;
      buf1_q    <= buf1_d;
      s_ready_q <= s_ready_d;
    end
  end

  // ---------------- read pointer synchronizer ----------------
  // Plain flop-to-flop chain: nothing may sit between the stages.
  logic [NUM_BITS-1:0] sync1_q, sync2_q;

  always_ff @(posedge w_clk or negedge w_rst) begin
    if (!w_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= rd_ptr_gray;
      sync2_q <= sync1_q;
    end
  end

  assign rd_ptr_gray_sync = sync2_q;

  // ---------------- level / almost-full ----------------
  logic [NUM_BITS-1:0] rd_bin, level;
  logic [NUM_BITS-1:0] wr_level_q;
  logic                af_q;

  always_comb begin
    rd_bin = '0;
    rd_bin[NUM_BITS-1] = sync2_q[NUM_BITS-1];
    for (int i = NUM_BITS-2; i >= 0; i--)
      rd_bin[i] = rd_bin[i+1] ^ sync2_q[i];
  end

  // Modular subtraction handles pointer wrap.
  assign level = w_ptr_bin - rd_bin;

  always_ff @(posedge w_clk or negedge w_rst) begin
    if (!w_rst) begin
      wr_level_q <= '0;
      af_q       <= 1'b0;
    end else begin
      wr_level_q <= level;
      af_q       <= (level >= AF_LVL);
    end
  end

  assign wr_level    = wr_level_q;
  assign almost_full = af_q;

endmodule

// File: doc/fifo_wr_front.md
FIFO_WR_FRONT -- requirements
Module: fifo_wr_front

Interface
REQ-001 Parameters SHALL be: NUM_BITS, default 4, pointer width including wrap bit (FIFO depth 2^(NUM_BITS-1) = 8); DATA_W, default 8, payload width; AF_THRESH, default 6, almost-full level.
REQ-002 Ports SHALL be (name direction width meaning):
- w_clk  in  1  write-domain clock
- w_rst  in  1  reset, asynchronous, active-low
- s_valid  in  1  upstream word valid
- s_data  in  DATA_W  upstream word
- s_ready  out  1  block can accept a word (registered)
- w_en  out  1  write request to the write-pointer/full stage and the memory
- w_data  out  DATA_W  word presented with w_en
- full  in  1  registered full flag from the write-pointer stage
- w_ptr_bin  in  NUM_BITS  binary write pointer from the write-pointer stage
- rd_ptr_gray  in  NUM_BITS  Gray read pointer, read-clock domain (asynchronous)
- rd_ptr_gray_sync  out  NUM_BITS  rd_ptr_gray after 2-flop synchronizer, to write-pointer stage
- wr_level  out  NUM_BITS  registered FIFO occupancy seen from write side
- almost_full  out  1  registered, wr_level >= AF_THRESH

Function
REQ-003 Upstream transfer SHALL occur on a w_clk edge where s_valid=1 and s_ready=1; downstream write SHALL occur on an edge where w_en=1 and full=0.
REQ-004 The block SHALL hold a 2-entry in-order skid buffer; occupancy count in {0,1,2}.
REQ-005 w_en SHALL equal (count != 0); w_data SHALL be the oldest buffered word; both SHALL stay stable while w_en=1 and full=1.
REQ-006 Next count SHALL be count + push - pop; push and pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-007 s_ready SHALL be registered, set to 1 when next count < 2, else 0; a push while s_ready=0 SHALL never occur.
REQ-008 With count=0 and full=0, a word accepted at edge N SHALL appear on w_en/w_data after edge N and be written at edge N+1 (one-cycle latency).
REQ-009 Under continuous s_valid=1 and full=0, throughput SHALL be one word per cycle with s_ready held at 1.
REQ-010 When full=1, pops SHALL stop; at most 2 words SHALL be buffered, then s_ready SHALL drop; no word SHALL be dropped or duplicated.
REQ-011 When full falls, the head word SHALL be written on the first edge with full=0.
REQ-012 rd_ptr_gray SHALL pass through exactly two w_clk flops before driving rd_ptr_gray_sync; no logic SHALL sit between the two flops.
REQ-013 rd_ptr_gray_sync SHALL be converted Gray-to-binary (b[MSB]=g[MSB], b[i]=b[i+1] XOR g[i]).
REQ-014 Level SHALL be (w_ptr_bin - rd_bin) modulo 2^NUM_BITS, range 0..2^(NUM_BITS-1), registered into wr_level one cycle after its inputs change.
REQ-015 Pointer wrap-around (e.g. w_ptr_bin=4'h1, rd_bin=4'hB) SHALL yield wr_level=6, not negative.
REQ-016 almost_full SHALL be registered alongside wr_level from the same computed level, with no additional cycle of lag.

Reset
REQ-017 While w_rst=0: count=0, s_ready=0, w_en=0, w_data=0, both synchronizer stages=0, rd_ptr_gray_sync=0, wr_level=0, almost_full=0.
REQ-018 On the first edge after w_rst rises, s_ready SHALL become 1.
REQ-019 Reset asserted mid-operation SHALL clear buffered words immediately, with no write issued after assertion.

Verification
REQ-020 Reset, then push 8'hA1 with full=0 -> w_en=1, w_data=8'hA1 on the next cycle; word written one edge later; s_ready stays 1.
REQ-021 full=1, stream 8'h01, 8'h02, 8'h03 -> 01 and 02 buffered, s_ready=0 after second push, 03 held upstream; release full -> 01, 02, 03 written in order on consecutive edges.
REQ-022 rd_ptr_gray steps 4'h0 -> 4'h1 -> rd_ptr_gray_sync shows 4'h1 exactly 2 edges later.
REQ-023 w_ptr_bin=4'h7, rd_ptr_gray=4'h0 (settled) -> wr_level=7, almost_full=1; rd_ptr_gray=4'h3 (bin 2) -> wr_level=5, almost_full=0.
REQ-024 w_ptr_bin=4'h1, rd_ptr_gray=4'hE (bin 4'hB) -> wr_level=6, almost_full=1.
REQ-025 Assert w_rst with 2 words buffered -> w_en=0, s_ready=0, wr_level=0 immediately; after release, no stale word is written.
